// File: rtl/dice_pkg.sv
// Shared types and constants for the dice roll sequencer: FSM states,
// button indices and the BCD side count selected by each die button.
package dice_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SPIN,
        SLOW,
        SHOW,
        SLEEP
    } state_t;

    localparam int NUM_BTNS = 7;

    localparam int BTN_D4   = 0;
    localparam int BTN_D6   = 1;
    localparam int BTN_D8   = 2;
    localparam int BTN_D10  = 3;
    localparam int BTN_D12  = 4;
    localparam int BTN_D20  = 5;
    localparam int BTN_D100 = 6;

    localparam logic [7:0] BCD_ONE = 8'h01;

    // Side count in BCD per button; the d100 entry is 00, which the wrap rule reads as 100.
    localparam logic [7:0] SIDES_BCD [NUM_BTNS] = '{8'h04, 8'h06, 8'h08, 8'h10, 8'h12, 8'h20, 8'h00};

    function automatic logic [2:0] lowest_set(input logic [NUM_BTNS-1:0] bits);
        lowest_set = 3'd0;
        for (int i = NUM_BTNS - 1; i >= 0; i--) begin
            if (bits[i]) begin
                lowest_set = 3'(i);
            end
        end
    endfunction

endpackage

// File: rtl/bcd_wrap_inc.sv
// Two-digit BCD increment that wraps to 01 once the die's top face is reached.
module bcd_wrap_inc
    import dice_pkg::*;
(
    input  logic [7:0] value,
    input  logic [7:0] sides,
    output logic [7:0] next_value
);

    always_comb begin
        next_value = BCD_ONE;
        if (value != sides) begin
            if (value[3:0] == 4'd9) begin
                next_value = (value[7:4] == 4'd9) ? 8'h00 : {value[7:4] + 4'd1, 4'h0};
            end else begin
                next_value = {value[7:4], value[3:0] + 4'd1};
            end
        end
    end

endmodule

// File: rtl/dice_roll_sequencer.sv
// Sequences one dice roll: spin while the die button is held, tick-paced
// deceleration after release, then show the result and blank after a timeout.
module dice_roll_sequencer
    import dice_pkg::*;
#(
    parameter int SLOW_STEPS = 8,
    parameter int SHOW_TICKS = 320,
    parameter int TCNT_W     = 9
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick,
    input  logic [NUM_BTNS-1:0] btn,
    output logic [3:0]          digit1,
    output logic [3:0]          digit10,
    output logic                blank,
    output logic                rolling,
    output logic                done
);

    localparam logic [TCNT_W-1:0] SLOW_LAST = TCNT_W'(SLOW_STEPS);
    localparam logic [TCNT_W-1:0] SHOW_LAST = TCNT_W'(SHOW_TICKS);
    localparam logic [TCNT_W-1:0] CNT_ONE   = TCNT_W'(1);

    state_t              state, state_n;
    logic [NUM_BTNS-1:0] btn_q;
    logic [7:0]          value, value_n;
    logic [7:0]          sides, sides_n;
    logic [2:0]          sel, sel_n;
    logic [TCNT_W-1:0]   step, step_n;
    logic [TCNT_W-1:0]   interval, interval_n;
    logic [TCNT_W-1:0]   tcnt, tcnt_n;
    logic [3:0]          digit1_n, digit10_n;
    logic                blank_n, done_n, rolling_n;

    logic [NUM_BTNS-1:0] rises;
    logic                press;
    logic [2:0]          first_idx;
    logic                held;
    logic [7:0]          inc_value;
    logic [TCNT_W-1:0]   tcnt_inc;
    logic [TCNT_W-1:0]   step_inc;

    assign rises     = btn & ~btn_q;
    assign press     = |rises;
    assign first_idx = lowest_set(rises);
    assign held      = |(btn & (7'b1 << sel));
    assign tcnt_inc  = tcnt + CNT_ONE;
    assign step_inc  = step + CNT_ONE;

    bcd_wrap_inc u_inc (
        .value      (value),
        .sides      (sides),
        .next_value (inc_value)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            btn_q    <= 7'h7F;
            value    <= BCD_ONE;
            sides    <= SIDES_BCD[BTN_D6];
            sel      <= 3'(BTN_D6);
            step     <= '0;
            interval <= '0;
            tcnt     <= '0;
            digit1   <= 4'd1;
            digit10  <= 4'd0;
            blank    <= 1'b0;
            rolling  <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            btn_q    <= btn;
            value    <= value_n;
            sides    <= sides_n;
            sel      <= sel_n;
            step     <= step_n;
            interval <= interval_n;
            tcnt     <= tcnt_n;
            digit1   <= digit1_n;
            digit10  <= digit10_n;
            blank    <= blank_n;
            rolling  <= rolling_n;
            done     <= done_n;
        end
    end

    always_comb begin
        state_n    = state;
        value_n    = value;
        sides_n    = sides;
        sel_n      = sel;
        step_n     = step;
        interval_n = interval;
        tcnt_n     = tcnt;
        digit1_n   = digit1;
        digit10_n  = digit10;
        blank_n    = blank;
        done_n     = 1'b0;

        case (state)
            IDLE, SHOW, SLEEP: begin
                if (press) begin
                    state_n = SPIN;
                    sel_n   = first_idx;
                    sides_n = SIDES_BCD[first_idx];
                    value_n = BCD_ONE;
                    blank_n = 1'b0;
                    tcnt_n  = '0;
                end else if (state == SHOW && tick) begin
                    if (tcnt_inc == SHOW_LAST) begin
                        state_n = SLEEP;
                        blank_n = 1'b1;
                        tcnt_n  = '0;
                    end else begin
                        tcnt_n = tcnt_inc;
                    end
                end
            end

            // Release wins over a coincident tick, so that tick neither advances nor refreshes.
            SPIN: begin
                if (!held) begin
                    state_n    = SLOW;
                    step_n     = '0;
                    interval_n = CNT_ONE;
                    tcnt_n     = '0;
                end else begin
                    value_n = inc_value;
                    if (tick) begin
                        digit10_n = value[7:4];
                        digit1_n  = value[3:0];
                    end
                end
            end

            SLOW: begin
                if (tick) begin
                    if (tcnt_inc == interval) begin
                        value_n    = inc_value;
                        digit10_n  = inc_value[7:4];
                        digit1_n   = inc_value[3:0];
                        step_n     = step_inc;
                        interval_n = interval + CNT_ONE;
                        tcnt_n     = '0;
                        if (step_inc == SLOW_LAST) begin
                            state_n = SHOW;
                            done_n  = 1'b1;
                        end
                    end else begin
                        tcnt_n = tcnt_inc;
                    end
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        rolling_n = (state_n == SPIN) || (state_n == SLOW);
    end

endmodule

// File: tb/tb_dice_roll_sequencer.sv
// Scoreboard bench for dice_roll_sequencer: roll results predicted from
// die arithmetic are queued at press time and checked on each done pulse.
module tb_dice_roll_sequencer;

    localparam int SLOW_STEPS = 8;
    localparam int SHOW_TICKS = 320;
    localparam int TCNT_W     = 9;

    typedef struct {
        int tens;
        int units;
        int ticks;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick  = 1'b0;
    logic [6:0] btn   = 7'd0;
    logic [3:0] digit1;
    logic [3:0] digit10;
    logic       blank;
    logic       rolling;
    logic       done;

    int   tests_run      = 0;
    int   tests_failed   = 0;
    int   release_events = 0;
    int   seen_releases  = 0;
    int   slow_ticks     = 0;
    int   show_ticks     = 0;
    int   done_count     = 0;
    bit   show_armed     = 1'b0;
    logic prev_blank     = 1'b0;
    exp_t sb_q[$];
    exp_t last_exp;
    int   sides_int [7] = '{4, 6, 8, 10, 12, 20, 100};

    always #5 clk = ~clk;

    always @(negedge clk) begin
        tick = ($urandom_range(0, 3) == 0);
    end

    dice_roll_sequencer #(
        .SLOW_STEPS (SLOW_STEPS),
        .SHOW_TICKS (SHOW_TICKS),
        .TCNT_W     (TCNT_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (tick),
        .btn     (btn),
        .digit1  (digit1),
        .digit10 (digit10),
        .blank   (blank),
        .rolling (rolling),
        .done    (done)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Die face after the spin and deceleration, counted as integers 1..N.
    function automatic exp_t roll_model(input logic [6:0] mask, input int held_cycles);
        exp_t e;
        int   n = 0;
        int   v;
        for (int i = 6; i >= 0; i--) begin
            if (mask[i]) n = sides_int[i];
        end
        v = ((held_cycles - 1 + SLOW_STEPS) % n) + 1;
        e.tens  = (v % 100) / 10;
        e.units = v % 10;
        e.ticks = SLOW_STEPS * (SLOW_STEPS + 1) / 2;
        return e;
    endfunction

    task automatic applyStimulus(input logic [6:0] mask, input int held_cycles, input bit expect_result);
        @(negedge clk);
        if (expect_result) begin
            last_exp = roll_model(mask, held_cycles);
            sb_q.push_back(last_exp);
        end
        btn = mask;
        @(negedge clk);
        checkOutput("rolling_after_press", int'(rolling), 1);
        checkOutput("blank_after_press", int'(blank), 0);
        repeat (held_cycles - 1) @(negedge clk);
        btn = 7'd0;
        release_events++;
    endtask

    task automatic waitDone(input int budget);
        int start = done_count;
        for (int i = 0; i < budget && done_count == start; i++) @(posedge clk);
        if (done_count == start) checkOutput("done_timeout", 0, 1);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst_n) begin
            sb_q.delete();
            show_armed    = 1'b0;
            seen_releases = release_events;
        end else begin
            if (release_events != seen_releases) begin
                seen_releases = release_events;
                slow_ticks    = 0;
            end else if (tick) begin
                slow_ticks++;
            end
            if (tick && show_armed) show_ticks++;
            if (rolling) show_armed = 1'b0;
            if (done) begin
                if (sb_q.size() == 0) begin
                    checkOutput("unexpected_done", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("result_tens", int'(digit10), e.tens);
                    checkOutput("result_units", int'(digit1), e.units);
                    checkOutput("slow_tick_count", slow_ticks, e.ticks);
                    checkOutput("rolling_at_done", int'(rolling), 0);
                end
                done_count++;
                show_armed = 1'b1;
                show_ticks = 0;
            end
            if (blank && !prev_blank && show_armed) begin
                checkOutput("show_tick_count", show_ticks, SHOW_TICKS);
                show_armed = 1'b0;
            end
        end
        prev_blank = blank;
    end

    initial begin
        logic [6:0] mask;
        int         held_cycles;
        int         waited;

        $display("[TB] starting dice_roll_sequencer bench");
        rst_n = 1'b0;
        btn   = 7'd0;
        repeat (3) @(negedge clk);
        checkOutput("reset_tens", int'(digit10), 0);
        checkOutput("reset_units", int'(digit1), 1);
        checkOutput("reset_blank", int'(blank), 0);
        checkOutput("reset_rolling", int'(rolling), 0);
        checkOutput("reset_done", int'(done), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("idle_rolling", int'(rolling), 0);

        rst_n = 1'b0;
        btn   = 7'b0000010;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("held_through_reset_rolling", int'(rolling), 0);
        checkOutput("held_through_reset_units", int'(digit1), 1);
        btn = 7'd0;
        repeat (2) @(negedge clk);

        applyStimulus(7'b0000010, 5, 1'b1);
        waitDone(2000);
        applyStimulus(7'b1000000, 100, 1'b1);
        waitDone(2000);
        applyStimulus(7'b0100001, 20, 1'b1);
        waitDone(2000);

        waited = 0;
        while (!blank && waited < 6000) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("sleep_blank", int'(blank), 1);
        checkOutput("sleep_tens_kept", int'(digit10), last_exp.tens);
        checkOutput("sleep_units_kept", int'(digit1), last_exp.units);
        applyStimulus(7'b0001000, 7, 1'b1);
        waitDone(2000);

        applyStimulus(7'b0010000, 9, 1'b1);
        repeat (10) @(negedge clk);
        btn = 7'b0000100;
        repeat (3) @(negedge clk);
        btn = 7'd0;
        waitDone(2000);

        applyStimulus(7'b0000100, 4, 1'b0);
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_tens", int'(digit10), 0);
        checkOutput("async_reset_units", int'(digit1), 1);
        checkOutput("async_reset_rolling", int'(rolling), 0);
        checkOutput("async_reset_blank", int'(blank), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int r = 0; r < 8; r++) begin
            mask        = 7'($urandom_range(1, 127));
            held_cycles = $urandom_range(1, 120);
            applyStimulus(mask, held_cycles, 1'b1);
            waitDone(2000);
        end

        repeat (4) @(negedge clk);
        checkOutput("scoreboard_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
